// File: rtl/tap_history_buffer.sv
// rtl/tap_history_buffer.sv - multi-channel circular tap history with zero-masked burst readout
module tap_history_buffer #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 2,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int FW = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CW-1:0]         in_chan,
   input  logic                  tap_start,
   input  logic [CW-1:0]         rd_chan,
   output logic                  tap_busy,
   output logic                  tap_valid,
   output logic [DATA_WIDTH-1:0] tap_data,
   output logic [AW-1:0]         tap_idx,
   output logic [CW-1:0]         tap_chan,
   output logic                  tap_last,
   output logic [FW-1:0]         fill
);

   localparam logic [AW-1:0] K_LAST = AW'(DEPTH - 1);
   localparam logic [FW-1:0] F_FULL = FW'(DEPTH);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   logic [DATA_WIDTH-1:0] r_mem  [CHANNELS][DEPTH];
   logic [AW-1:0]         r_wptr [CHANNELS];
   logic [FW-1:0]         r_fill [CHANNELS];

   state_t                r_state;
   logic                  r_busy;
   logic                  r_valid;
   logic                  r_last;
   logic [AW-1:0]         r_k;
   logic [CW-1:0]         r_ch;

   logic                  w_push;
   logic                  w_start;
   logic [AW:0]           w_sum;
   logic [AW-1:0]         w_rd_idx;
   logic                  w_in_fill;

   // Pushes are taken whenever no burst is running; out-of-range channels complete
   // the handshake but never touch storage. A flush drops the push.
   assign in_ready = ~r_busy;
   assign w_push   = in_valid & ~r_busy & ~rst & ~flush & (int'(in_chan) < CHANNELS);
   assign w_start  = tap_start & (int'(rd_chan) < CHANNELS);

   // Newest-first read address: (wptr - 1 - k) mod DEPTH, done without a power-of-two wrap.
   assign w_sum     = {1'b0, r_wptr[r_ch]} + (AW+1)'(DEPTH - 1) - {1'b0, r_k};
   assign w_rd_idx  = (w_sum >= (AW+1)'(DEPTH)) ? AW'(w_sum - (AW+1)'(DEPTH)) : w_sum[AW-1:0];
   assign w_in_fill = (FW'(r_k) < r_fill[r_ch]);

   // Storage is frozen during a burst, so the tap sample is read straight from the array.
   assign tap_data = (r_valid && w_in_fill) ? r_mem[r_ch][w_rd_idx] : '0;
   assign tap_busy = r_busy;
   assign tap_valid = r_valid;
   assign tap_idx  = r_k;
   assign tap_chan = r_ch;
   assign tap_last = r_last;
   assign fill     = (int'(rd_chan) < CHANNELS) ? r_fill[rd_chan] : '0;

   // Sample array write; contents are never cleared because the fill count masks stale data.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[in_chan][r_wptr[in_chan]] <= in_data;
      end
   end

   // Per-channel write pointer and saturating fill count.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_wptr[c] <= '0;
            r_fill[c] <= '0;
         end
      end else if (w_push) begin
         r_wptr[in_chan] <= (r_wptr[in_chan] == K_LAST) ? '0 : r_wptr[in_chan] + 1'b1;
         if (r_fill[in_chan] != F_FULL) begin
            r_fill[in_chan] <= r_fill[in_chan] + 1'b1;
         end
      end
   end

   // Burst sequencer: one beat per cycle for DEPTH cycles, aborted by flush or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_k     <= '0;
         r_ch    <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_BURST;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_last  <= (K_LAST == '0);
                  r_k     <= '0;
                  r_ch    <= rd_chan;
               end
            end
            S_BURST: begin
               if (r_k == K_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_k     <= '0;
               end else begin
                  r_k    <= r_k + 1'b1;
                  r_last <= ((r_k + 1'b1) == K_LAST);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
